trig_seq_unit: RTL and testbench
================================

Name: trig_seq_unit

Overview:
- Multi-cycle CORDIC sequencer for the SIN and COS processing ops. It sits beside the ALU in the execute stage.
- On a trig op, the execute stage pulses start with trigControl as cos_sel. The block stalls the pipeline while it iterates, then presents a sign-extended fixed-point result for the memToReg=2'b11 writeback path.

Parameters:
- DATA_W, 32, operand/result width on the pipeline side.
- ITER, 14, CORDIC iterations; legal range 8..16.
- FRAC_W, 14, fractional bits of the result; result format signed Q1.FRAC_W.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  trig op valid in execute.
- cos_sel  in  1  1=COS, 0=SIN (trigControl).
- angle_i  in  DATA_W  operand; only bits [15:0] used, binary angle units (0x10000 = 2*pi).
- flush  in  1  pipeline flush (used only with TRIG_FLUSH_EN).
- stall_o  out  1  hold IF/ID/EX pipeline registers.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  DATA_W  signed Q1.FRAC_W, sign-extended.

Behaviour:
- Reset when rst_n=0 at a clk edge: state=IDLE, result_o=0, done_o=0, busy_o=0, iteration counter=0. Reset mid-operation aborts immediately; no done_o.
- FSM states and transitions:
  - IDLE: on start=1, latch cos_sel, quadrant q=angle_i[15:14] and residual r=angle_i[13:0]. Load x=K=round(0.6072529*2^FRAC_W) (9949 for FRAC_W=14), y=0, z=r zero-extended. Go to ROT, counter=0.
  - ROT: one micro-rotation per cycle with i=counter, d=sign(z). x'=x-d*(y>>>i); y'=y+d*(x>>>i); z'=z-d*atan_tab[i].
    - atan_tab[i] = round(atan(2^-i)*2^16/(2*pi)), a 16-entry constant ROM.
    - Leave ROT when counter==ITER-1; otherwise counter++.
  - FIX: c=x, s=y. Quadrant map:
    - q0: cos=c, sin=s.
    - q1: cos=-s, sin=c.
    - q2: cos=-c, sin=-s.
    - q3: cos=s, sin=-c.
    - Register the selected value, sign-extended to DATA_W, into result_o. Go to DONE.
  - DONE: done_o=1 for this cycle only. Go to IDLE.
- Internal x/y/z are FRAC_W+4 bits signed; arithmetic shifts; no saturation needed. Magnitudes stay ≤ 1.0 plus guard bits.
- Latency: start sampled at edge t0; done_o high during cycle t0+ITER+2 (16 cycles at default).
- stall_o = (state==IDLE & start) | state==ROT | state==FIX. It is combinational from start so the trig op is held in EX from its first cycle. stall_o is low in DONE so the op advances with a valid result.
- busy_o = state≠IDLE.
- start while busy_o=1 is ignored; the latched operands do not change.
- start in DONE is ignored; it is accepted from the next IDLE cycle.
- result_o holds its value until the next FIX; it is not cleared by done_o falling.
- Accuracy: |error| ≤ 4 LSB of Q1.14 for all 65536 angles at ITER=14.

Optional Feature:
- TRIG_FLUSH_EN defined: flush=1 in any state forces IDLE next cycle, with done_o=0 and result_o unchanged. stall_o deasserts the cycle after flush. flush has priority over start in IDLE.
- TRIG_FLUSH_EN undefined: the flush input is ignored; an operation always runs to DONE.

Test Plan:
- SIN/COS at angle_i=0x0000:
  - cos_sel=1 → result_o=0x00004000 ±4.
  - cos_sel=0 → 0x00000000 ±4.
  - done_o exactly 16 cycles after start.
- Angle 0x2000 (pi/4), SIN → 11585 ±4. Angle 0x4000, SIN → 16384 ±4. Angle 0x8000, COS → 0xFFFFC000 ±4 (sign-extended -16384).
- Angle 0xC000 (3pi/2), SIN → 0xFFFFC000 ±4, COS → 0 ±4. Checks q3 mapping and sign extension in the upper 16 bits.
- start pulsed again at cycle 5 of an operation with different angle/cos_sel → ignored; first result unchanged; single done_o; stall_o continuous cycles 0..15.
- rst_n=0 at cycle 7 of an operation → next cycle busy_o=0, stall_o=0, result_o=0, no done_o. A new start then completes normally.
- TRIG_FLUSH_EN built: flush at cycle 3 → IDLE next cycle, no done_o, result_o keeps its prior value. Without the macro the same stimulus completes with done_o at cycle 16.

Source files
------------

// File: rtl/trig_seq_unit.sv
// trig_seq_unit
//   Multi-cycle CORDIC sequencer for the SIN / COS ops. It sits beside the ALU
//   in the execute stage, stalls the pipeline while it iterates, and then
//   presents a sign-extended signed Q1.FRAC_W result for writeback.
//
// Ports
//   clk       in   pipeline clock
//   rst_n     in   synchronous active-low reset
//   start     in   trig op valid in execute
//   cos_sel   in   1 = COS, 0 = SIN
//   angle_i   in   operand; bits [15:0] are a binary angle (0x10000 = 2*pi)
//   flush     in   pipeline flush (honoured only when TRIG_FLUSH_EN is defined)
//   stall_o   out  hold IF/ID/EX pipeline registers
//   busy_o    out  operation in progress
//   done_o    out  one-cycle result-valid pulse
//   result_o  out  signed Q1.FRAC_W result, sign-extended to DATA_W
//
// Configuration
//   TRIG_FLUSH_EN  when defined, flush aborts any operation back to IDLE.
//                  When undefined, flush is ignored.

module trig_seq_unit #(
  parameter int DATA_W = 32,
  parameter int ITER   = 14,
  parameter int FRAC_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cos_sel,
  input  logic [DATA_W-1:0] angle_i,
  input  logic              flush,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  // Datapath width: FRAC_W fraction bits plus integer/sign headroom.
  localparam int IW = FRAC_W + 4;
  localparam int CW = 4;

  // CORDIC gain compensation K = round(0.6072529 * 2^FRAC_W).
  localparam logic [63:0] K_NUM = 64'd6072529 << FRAC_W;
  localparam logic signed [IW-1:0] K_INIT = IW'((K_NUM + 64'd5000000) / 64'd10000000);

  typedef enum logic [1:0] {IDLE, ROT, FIX, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 cos_q;
  logic [1:0]           quad_q;
  logic signed [IW-1:0] x_q, y_q, z_q;
  logic signed [IW-1:0] x_d, y_d, z_d;
  logic                 done_q;
  logic [DATA_W-1:0]    result_q;

  logic signed [IW-1:0] xShift, yShift, atanVal, selVal;
  logic                 flushHit;

`ifdef TRIG_FLUSH_EN
  assign flushHit = flush;
  logic unusedAngle;
  assign unusedAngle = ^angle_i[DATA_W-1:16];
`else
  assign flushHit = 1'b0;
  logic unusedIn;
  assign unusedIn = ^{angle_i[DATA_W-1:16], flush};
`endif

  // atan(2^-i) in binary angle units (2^16 per turn), rounded.
  function automatic logic [15:0] atanRom(input logic [CW-1:0] idx);
    case (idx)
      4'd0:    atanRom = 16'd8192;
      4'd1:    atanRom = 16'd4836;
      4'd2:    atanRom = 16'd2555;
      4'd3:    atanRom = 16'd1297;
      4'd4:    atanRom = 16'd651;
      4'd5:    atanRom = 16'd326;
      4'd6:    atanRom = 16'd163;
      4'd7:    atanRom = 16'd81;
      4'd8:    atanRom = 16'd41;
      4'd9:    atanRom = 16'd20;
      4'd10:   atanRom = 16'd10;
      4'd11:   atanRom = 16'd5;
      4'd12:   atanRom = 16'd3;
      4'd13:   atanRom = 16'd1;
      4'd14:   atanRom = 16'd1;
      default: atanRom = 16'd0;
    endcase
  endfunction

  // One micro-rotation: the sign of the residual angle z picks the rotation
  // direction, driving z toward zero.
  always_comb begin
    xShift  = x_q >>> cnt_q;
    yShift  = y_q >>> cnt_q;
    atanVal = $signed({{(IW-16){1'b0}}, atanRom(cnt_q)});
    if (z_q[IW-1]) begin
      x_d = x_q + yShift;
      y_d = y_q - xShift;
      z_d = z_q + atanVal;
    end else begin
      x_d = x_q - yShift;
      y_d = y_q + xShift;
      z_d = z_q - atanVal;
    end
  end

  // The rotation only covers the first quadrant; the top two angle bits fold
  // the final (cos, sin) pair back into the real quadrant.
  always_comb begin
    case (quad_q)
      2'd0:    selVal = cos_q ? x_q  : y_q;
      2'd1:    selVal = cos_q ? -y_q : x_q;
      2'd2:    selVal = cos_q ? -x_q : -y_q;
      default: selVal = cos_q ? y_q  : -x_q;
    endcase
  end

  // Sequencer: latch operands on start, iterate ITER times, fold quadrant and
  // register the result, then pulse done for one cycle. A flush (when enabled)
  // drops straight back to IDLE without touching the previous result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cos_q    <= 1'b0;
      quad_q   <= 2'd0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (flushHit) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              cos_q   <= cos_sel;
              quad_q  <= angle_i[15:14];
              x_q     <= K_INIT;
              y_q     <= '0;
              z_q     <= $signed({{(IW-14){1'b0}}, angle_i[13:0]});
              cnt_q   <= '0;
              state_q <= ROT;
            end
          end
          ROT: begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            if (cnt_q == CW'(ITER - 1)) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          FIX: begin
            result_q <= {{(DATA_W-IW){selVal[IW-1]}}, selVal};
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Stall is combinational from start so the trig op is frozen in EX from its
  // very first cycle; it drops in DONE so the op advances with its result.
  assign stall_o  = ((state_q == IDLE) && start) || (state_q == ROT) || (state_q == FIX);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_trig_seq_unit.sv
module tb_trig_seq_unit;

  localparam int  DATA_W = 32;
  localparam int  ITER   = 14;
  localparam real PI     = 3.14159265358979;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              cos_sel;
  logic [DATA_W-1:0] angle_i;
  logic              flush;
  logic              stall_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;

  int nChecks = 0;
  int nFails  = 0;

  trig_seq_unit #(.DATA_W(DATA_W), .ITER(ITER), .FRAC_W(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cos_sel  (cos_sel),
    .angle_i  (angle_i),
    .flush    (flush),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Ideal trig value in Q1.14 from the binary angle.
  function automatic int refTrig(input int ang, input bit isCos);
    real th, v;
    th = 2.0 * PI * real'(ang) / 65536.0;
    v  = isCos ? $cos(th) : $sin(th);
    return $rtoi(v * 16384.0 + ((v >= 0.0) ? 0.5 : -0.5));
  endfunction

  // Runs one operation starting in cycle 0. Optionally re-pulses start with
  // other operands at cycle restartAt and pulses flush at cycle flushAt.
  // Reports the first done cycle, number of done pulses and stall errors.
  task automatic applyStimulus(input logic [31:0] ang, input logic cs,
                               input int restartAt, input logic [31:0] ang2,
                               input logic cs2, input int flushAt,
                               output int doneCycle, output int doneCount,
                               output int stallBad, output logic busyAfterFlush);
    doneCycle      = -1;
    doneCount      = 0;
    stallBad       = 0;
    busyAfterFlush = 1'b1;
    @(negedge clk);
    start   = 1'b1;
    angle_i = ang;
    cos_sel = cs;
    #1;
    if (stall_o !== 1'b1) stallBad++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (c == flushAt);
      if (c == restartAt) begin
        start   = 1'b1;
        angle_i = ang2;
        cos_sel = cs2;
      end
      #1;
      if (done_o === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (c == flushAt + 1) busyAfterFlush = busy_o;
      if (c <= ITER + 1 && stall_o !== 1'b1) stallBad++;
      if (c == ITER + 2 && stall_o !== 1'b0) stallBad++;
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nChecks++;
    if (busy_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    nChecks++;
    if (done_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    nChecks++;
    if (stall_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
    nChecks++;
    if (result_o !== 32'h0) begin nFails++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
    rst_n = 1'b1;
  endtask

  // Directed angles, including the quadrant boundaries and sign extension.
  task automatic test_directed();
    logic [15:0] angs [7] = '{16'h0000, 16'h0000, 16'h2000, 16'h4000, 16'h8000, 16'hC000, 16'hC000};
    bit          css  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          exps [7] = '{16384, 0, 11585, 16384, -16384, -16384, 0};
    int dc, dn, sb, diff;
    logic bf;
    for (int i = 0; i < 7; i++) begin
      applyStimulus({16'h0, angs[i]}, css[i], -1, 32'h0, 1'b0, -1, dc, dn, sb, bf);
      diff = $signed(result_o) - exps[i];
      nChecks++;
      if (diff > 4 || diff < -4) begin
        nFails++;
        $display("[TB] FAIL directed_result[%0d]: got %h expected %0d +-4", i, result_o, exps[i]);
      end
      nChecks++;
      if (dc !== ITER + 2 || dn !== 1) begin
        nFails++;
        $display("[TB] FAIL directed_done[%0d]: got cycle %0d count %0d expected cycle %0d count 1", i, dc, dn, ITER + 2);
      end
      nChecks++;
      if (sb !== 0) begin nFails++; $display("[TB] FAIL directed_stall[%0d]: got %0d bad cycles expected 0", i, sb); end
    end
  endtask

  // Random operands (upper angle bits are random too and must be ignored).
  task automatic test_random();
    logic [31:0] ang;
    bit cs;
    int dc, dn, sb, diff, expv;
    logic bf;
    for (int i = 0; i < 12; i++) begin
      ang  = $urandom();
      cs   = $urandom_range(0, 1) == 1;
      expv = refTrig(int'(ang[15:0]), cs);
      applyStimulus(ang, cs, -1, 32'h0, 1'b0, -1, dc, dn, sb, bf);
      diff = $signed(result_o) - expv;
      nChecks++;
      if (diff > 8 || diff < -8) begin
        nFails++;
        $display("[TB] FAIL random_result ang=%h cos=%0d: got %h expected %0d", ang, cs, result_o, expv);
      end
      nChecks++;
      if (dc !== ITER + 2 || dn !== 1) begin
        nFails++;
        $display("[TB] FAIL random_done: got cycle %0d count %0d expected cycle %0d count 1", dc, dn, ITER + 2);
      end
    end
  endtask

  // A second start mid-operation must be ignored.
  task automatic test_back_to_back();
    int dc, dn, sb, diff;
    logic bf;
    applyStimulus(32'h2000, 1'b0, 5, 32'h8000, 1'b1, -1, dc, dn, sb, bf);
    diff = $signed(result_o) - 11585;
    nChecks++;
    if (diff > 4 || diff < -4) begin nFails++; $display("[TB] FAIL b2b_result: got %h expected 11585 +-4", result_o); end
    nChecks++;
    if (dn !== 1 || dc !== ITER + 2) begin nFails++; $display("[TB] FAIL b2b_done: got cycle %0d count %0d expected %0d/1", dc, dn, ITER + 2); end
    nChecks++;
    if (sb !== 0) begin nFails++; $display("[TB] FAIL b2b_stall: got %0d bad cycles expected 0", sb); end
  endtask

  // Reset at cycle 7 aborts the op and clears the result.
  task automatic test_reset_mid();
    int dc, dn, sb, diff, seen;
    logic bf;
    @(negedge clk);
    start   = 1'b1;
    angle_i = 32'h4000;
    cos_sel = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    nChecks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rstmid_ctrl: got busy %b stall %b expected 0 0", busy_o, stall_o);
    end
    nChecks++;
    if (result_o !== 32'h0) begin nFails++; $display("[TB] FAIL rstmid_result: got %h expected 0", result_o); end
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (done_o === 1'b1) seen++;
    end
    nChecks++;
    if (seen !== 0) begin nFails++; $display("[TB] FAIL rstmid_nodone: got %0d pulses expected 0", seen); end
    applyStimulus(32'h4000, 1'b0, -1, 32'h0, 1'b0, -1, dc, dn, sb, bf);
    diff = $signed(result_o) - 16384;
    nChecks++;
    if (diff > 4 || diff < -4 || dc !== ITER + 2) begin
      nFails++;
      $display("[TB] FAIL rstmid_restart: got %h at cycle %0d expected 16384 +-4 at %0d", result_o, dc, ITER + 2);
    end
  endtask

  // Flush at cycle 3. The previous result is sin(pi/2) = 16384.
  task automatic test_flush();
    int dc, dn, sb, diff;
    logic bf;
    applyStimulus(32'h8000, 1'b0, -1, 32'h0, 1'b0, 3, dc, dn, sb, bf);
`ifdef TRIG_FLUSH_EN
    diff = $signed(result_o) - 16384;
    nChecks++;
    if (bf !== 1'b0) begin nFails++; $display("[TB] FAIL flush_busy: got %b expected 0", bf); end
    nChecks++;
    if (dn !== 0) begin nFails++; $display("[TB] FAIL flush_nodone: got %0d pulses expected 0", dn); end
    nChecks++;
    if (diff > 4 || diff < -4) begin nFails++; $display("[TB] FAIL flush_result: got %h expected 16384 +-4", result_o); end
`else
    diff = $signed(result_o);
    nChecks++;
    if (dc !== ITER + 2 || dn !== 1) begin nFails++; $display("[TB] FAIL noflush_done: got cycle %0d count %0d expected %0d/1", dc, dn, ITER + 2); end
    nChecks++;
    if (diff > 4 || diff < -4) begin nFails++; $display("[TB] FAIL noflush_result: got %h expected 0 +-4", result_o); end
    nChecks++;
    if (sb !== 0) begin nFails++; $display("[TB] FAIL noflush_stall: got %0d bad cycles expected 0", sb); end
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    cos_sel = 1'b0;
    angle_i = '0;
    flush   = 1'b0;
    $display("[TB] starting trig_seq_unit bench");
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
